// File: rtl/spi_dac_rx.sv
// MCP4911-style SPI write receiver: oversamples the serial DAC link on sysclk,
// decodes 16-bit channel-A writes and presents the loaded code on LD.
module spi_dac_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       dac_sdi,
  input  logic       dac_sck,
  input  logic       dac_cs,
  input  logic       dac_ld,
  output logic [9:0] dac_data,
  output logic       dac_gain1x,
  output logic       dac_buf,
  output logic       dac_active,
  output logic       dac_update,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] sdi_sync, sck_sync, cs_sync, ld_sync;
  logic                   sck_prev, cs_prev, ld_prev;
  logic                   sdi_cur, sck_cur, cs_cur, ld_cur;

  logic                   sck_rise, cs_fall, cs_rise, ld_fall, sdi_bit;

  state_t                 state;
  logic [15:0]            shift_reg;
  logic [CW-1:0]          bit_cnt;
  logic [12:0]            hold;
  logic                   hold_valid;
  logic                   ld_pend;

  assign sdi_cur = sdi_sync[SYNC_STAGES-1];
  assign sck_cur = sck_sync[SYNC_STAGES-1];
  assign cs_cur  = cs_sync[SYNC_STAGES-1];
  assign ld_cur  = ld_sync[SYNC_STAGES-1];

  // Synchronizers, previous-value registers and registered edge events.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sdi_sync <= '0;
      sck_sync <= '1;
      cs_sync  <= '1;
      ld_sync  <= '1;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
      ld_prev  <= 1'b1;
      sck_rise <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      ld_fall  <= 1'b0;
      sdi_bit  <= 1'b0;
    end else begin
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], dac_sdi};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], dac_sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], dac_cs};
      ld_sync  <= {ld_sync[SYNC_STAGES-2:0], dac_ld};
      sck_prev <= sck_cur;
      cs_prev  <= cs_cur;
      ld_prev  <= ld_cur;
      sck_rise <= ~sck_prev & sck_cur;
      cs_fall  <= cs_prev & ~cs_cur;
      cs_rise  <= ~cs_prev & cs_cur;
      ld_fall  <= ld_prev & ~ld_cur;
      sdi_bit  <= sdi_cur;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      ld_pend    <= 1'b0;
      dac_data   <= '0;
      dac_gain1x <= 1'b1;
      dac_buf    <= 1'b0;
      dac_active <= 1'b0;
      dac_update <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      dac_update <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            shift_reg <= {shift_reg[14:0], sdi_bit};
            if (bit_cnt != CW'(FRAME_BITS + 1))
              bit_cnt <= bit_cnt + CW'(1);
          end
          if (cs_rise)
            state <= CHECK;
        end
        CHECK: begin
          state <= IDLE;
          if (bit_cnt == CW'(FRAME_BITS)) begin
            // Channel-B writes are valid frames for an unsupported channel: drop silently.
            if (!shift_reg[15]) begin
              hold       <= shift_reg[14:2];
              hold_valid <= 1'b1;
              frame_done <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A load request meeting CHECK waits one cycle so it picks up the new word.
      ld_pend <= ld_fall | (ld_pend && state == CHECK);
      if (ld_pend && state != CHECK && hold_valid) begin
        {dac_buf, dac_gain1x, dac_active, dac_data} <= hold;
        dac_update <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed bench for spi_dac_rx: a transaction-level model schedules expected
// pulses and register values per cycle; one compare process checks every cycle.
module tb_spi_dac_rx;

  localparam int FRAME = 16;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dac_sdi = 1'b0;
  logic       dac_sck = 1'b1;
  logic       dac_cs = 1'b1;
  logic       dac_ld = 1'b1;
  logic [9:0] dac_data;
  logic       dac_gain1x, dac_buf, dac_active;
  logic       dac_update, frame_done, frame_err;

  spi_dac_rx #(.SYNC_STAGES(2), .FRAME_BITS(FRAME)) dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .dac_sdi(dac_sdi), .dac_sck(dac_sck), .dac_cs(dac_cs), .dac_ld(dac_ld),
    .dac_data(dac_data), .dac_gain1x(dac_gain1x), .dac_buf(dac_buf),
    .dac_active(dac_active), .dac_update(dac_update),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #10 sysclk = ~sysclk;

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge sysclk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Model state: expected outputs {buf, gain1x, active, data}, holding word, schedules.
  bit          exp_done[int];
  bit          exp_err[int];
  logic [12:0] upd_val[int];
  logic [12:0] m_out = 13'h0800;
  logic [12:0] m_hold = '0;
  bit          m_hv = 1'b0;
  int          last_check = -100;

  int total = 0, bad = 0;
  int upd_seen_cyc = -1, done_count = 0, err_count = 0, upd_count = 0;
  bit finished = 1'b0;
  bit e_done, e_err, e_upd;

  always @(negedge sysclk) begin
    if (cyc >= 1 && !finished) begin
      if (!rst_q) begin
        m_out  = 13'h0800;
        e_done = 1'b0;
        e_err  = 1'b0;
        e_upd  = 1'b0;
      end else begin
        e_done = exp_done.exists(cyc);
        e_err  = exp_err.exists(cyc);
        e_upd  = upd_val.exists(cyc);
        if (e_upd) m_out = upd_val[cyc];
      end
      total++;
      if ({frame_done, frame_err, dac_update} !== {e_done, e_err, e_upd}) begin
        bad++;
        $display("FAIL pulses cyc=%0d done/err/upd got=%b want=%b", cyc,
                 {frame_done, frame_err, dac_update}, {e_done, e_err, e_upd});
      end
      total++;
      if ({dac_buf, dac_gain1x, dac_active, dac_data} !== m_out) begin
        bad++;
        $display("FAIL regs cyc=%0d got=%h want=%h", cyc,
                 {dac_buf, dac_gain1x, dac_active, dac_data}, m_out);
      end
      if (dac_update === 1'b1) begin
        upd_count++;
        upd_seen_cyc = cyc;
      end
      if (frame_done === 1'b1) done_count++;
      if (frame_err === 1'b1) err_count++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // LD sampled low at edge k -> transfer 4 edges later, one more if CHECK is then active.
  task automatic sched_ld(input int k);
    int t;
    t = k + 4;
    if (t == last_check) t++;
    if (m_hv) upd_val[t] = m_hold;
  endtask

  task automatic pulse_ld(output int k);
    dac_ld = 1'b0;
    k = cyc + 1;
    sched_ld(k);
    wait_cyc(4);
    dac_ld = 1'b1;
    wait_cyc(12);
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input bit abort,
                            input bit with_ld, output int ldk);
    int c;
    ldk = -1;
    dac_cs = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < nbits; i++) begin
      dac_sck = 1'b0;
      dac_sdi = w[15-i];
      wait_cyc(4);
      dac_sck = 1'b1;
      wait_cyc(4);
    end
    if (abort) begin
      rst_n  = 1'b0;
      dac_cs = 1'b1;
      m_hold = '0;
      m_hv   = 1'b0;
      wait_cyc(1);
      rst_n = 1'b1;
      wait_cyc(12);
    end else begin
      dac_cs = 1'b1;
      c = cyc + 1;
      last_check = c + 4;
      if (nbits == FRAME) begin
        if (!w[15]) begin
          m_hold = w[14:2];
          m_hv   = 1'b1;
          exp_done[c+4] = 1'b1;
        end
      end else begin
        exp_err[c+4] = 1'b1;
      end
      if (with_ld) begin
        dac_ld = 1'b0;
        ldk = c;
        sched_ld(c);
      end
      wait_cyc(4);
      dac_ld = 1'b1;
      wait_cyc(12);
    end
  endtask

  initial begin
    int k, dummy;
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    chk("rst_data", 32'(dac_data), 32'h0);
    chk("rst_gain1x", 32'(dac_gain1x), 32'h1);
    chk("rst_active", 32'(dac_active), 32'h0);
    chk("rst_pulses", 32'({frame_done, frame_err, dac_update}), 32'h0);

    // Channel A, BUF=0, GA_n=1, SHDN_n=1, code 3AB.
    send_frame(16'h3EAC, 16, 1'b0, 1'b0, dummy);
    chk("f1_done_count", 32'(done_count), 32'h1);
    pulse_ld(k);
    chk("f1_ld_latency", 32'(upd_seen_cyc - k), 32'd4);
    chk("f1_data", 32'(dac_data), 32'h3AB);
    chk("f1_gain1x", 32'(dac_gain1x), 32'h1);
    chk("f1_active", 32'(dac_active), 32'h1);
    chk("f1_buf", 32'(dac_buf), 32'h0);

    // 15-bit frame aborts; LD reloads the previous word.
    send_frame(16'h3C00, 15, 1'b0, 1'b0, dummy);
    chk("short_err_count", 32'(err_count), 32'h1);
    pulse_ld(k);
    chk("short_data", 32'(dac_data), 32'h3AB);
    chk("short_upd_count", 32'(upd_count), 32'h2);

    // Channel B write (code 155) is dropped silently.
    send_frame(16'hB554, 16, 1'b0, 1'b0, dummy);
    chk("chb_done_count", 32'(done_count), 32'h1);
    chk("chb_err_count", 32'(err_count), 32'h1);
    pulse_ld(k);
    chk("chb_data", 32'(dac_data), 32'h3AB);

    // Reset after 8 bits, then a full frame with code 200.
    send_frame(16'h3555, 8, 1'b1, 1'b0, dummy);
    chk("abort_err_count", 32'(err_count), 32'h1);
    chk("abort_data", 32'(dac_data), 32'h0);
    send_frame(16'h3800, 16, 1'b0, 1'b0, dummy);
    pulse_ld(k);
    chk("post_rst_latency", 32'(upd_seen_cyc - k), 32'd4);
    chk("post_rst_data", 32'(dac_data), 32'h200);

    // LD coinciding with CHECK: BUF=1, GA_n=0, SHDN_n=1, code 0FF.
    send_frame(16'h53FC, 16, 1'b0, 1'b1, k);
    chk("coinc_latency", 32'(upd_seen_cyc - k), 32'd5);
    chk("coinc_data", 32'(dac_data), 32'h0FF);
    chk("coinc_buf", 32'(dac_buf), 32'h1);
    chk("coinc_gain1x", 32'(dac_gain1x), 32'h0);
    chk("coinc_active", 32'(dac_active), 32'h1);

    // SCK activity with CS high must be ignored.
    for (int i = 0; i < 6; i++) begin
      dac_sck = 1'b0;
      dac_sdi = 1'(i);
      wait_cyc(4);
      dac_sck = 1'b1;
      wait_cyc(4);
    end
    wait_cyc(10);
    chk("idle_sck_data", 32'(dac_data), 32'h0FF);
    chk("idle_sck_events", 32'(done_count + err_count), 32'd4);

    finished = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
